// File: rtl/cpu_pkg.sv
// Shared types for the multicycle CPU: opcodes, FSM states, flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JC   = 4'hA,
    OP_JN   = 4'hB,
    OP_IN   = 4'hC,
    OP_OUT  = 4'hD,
    OP_CMP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_MEM   = 2'd3
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_W = 3;

  // Opcodes that go through the ALU and update the flags.
  function automatic logic is_alu_op(input opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_CMP};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result and Z/C/N flags for ADD/ADDI/SUB/CMP/AND/OR.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op_i opcode, a_i/b_i operands, result_o result, flags_o {N,C,Z} indexed by FLAG_*.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e             op_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [DATA_W-1:0]   result_o,
  output logic [FLAG_W-1:0]   flags_o
);

  logic [DATA_W:0] wide;
  logic            carry;

  always_comb begin
    wide  = '0;
    carry = 1'b0;
    case (op_i)
      OP_ADD, OP_ADDI: begin
        wide  = {1'b0, a_i} + {1'b0, b_i};
        carry = wide[DATA_W];
      end
      // C means borrow for subtraction: set when a < b unsigned.
      OP_SUB, OP_CMP: begin
        wide  = {1'b0, a_i} - {1'b0, b_i};
        carry = (a_i < b_i);
      end
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      default: wide = '0;
    endcase
    result_o         = wide[DATA_W-1:0];
    flags_o          = '0;
    flags_o[FLAG_Z]  = (result_o == '0);
    flags_o[FLAG_C]  = carry;
    flags_o[FLAG_N]  = result_o[DATA_W-1];
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle accumulator-style CPU with unified program/data memory, run/step control and I/O ports.
// Latency: ALU/NOP/jump 2 cycles, LD/ST 3 cycles, IN/OUT 2 cycles plus handshake stall.
// Backpressure: IN stalls in EXEC until in_valid; OUT holds out_valid/out_data until out_ready.
// Ports: clk/reset (sync, active-high); run/step control; prog_* memory load port (HALT only);
//        in_* / out_* valid-ready ports; pc/instr/halted debug; dbg_sel -> dbg_data register readback.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 4,
  parameter  int REG_N  = 4,
  localparam int RS_W   = $clog2(REG_N),
  localparam int IW     = 4 + 2*RS_W + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [IW-1:0]     prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [IW-1:0]     instr,
  output logic              halted,
  input  logic [RS_W-1:0]   dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [IW-1:0]       instr_q;
  logic [DATA_W-1:0]   regs_q [REG_N];
  logic [FLAG_W-1:0]   flags_q;
  logic                step_q;   // current instruction was started by step, not run
  logic [IW-1:0]       mem_q [2**ADDR_W];

  // Decode of the latched instruction {op, rd, rs, imm}.
  opcode_e             op;
  logic [RS_W-1:0]     rd;
  logic [RS_W-1:0]     rs;
  logic [ADDR_W-1:0]   imm;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   rs_val;
  logic [ADDR_W-1:0]   mem_addr;

  assign op       = opcode_e'(instr_q[IW-1 -: 4]);
  assign rd       = instr_q[ADDR_W+RS_W +: RS_W];
  assign rs       = instr_q[ADDR_W +: RS_W];
  assign imm      = instr_q[ADDR_W-1:0];
  assign rd_val   = regs_q[rd];
  assign rs_val   = regs_q[rs];
  assign mem_addr = rs_val[ADDR_W-1:0];

  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_res;
  logic [FLAG_W-1:0]   alu_flags;

  assign alu_b = (op == OP_ADDI) ? DATA_W'(imm) : rs_val;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op),
    .a_i      (rd_val),
    .b_i      (alu_b),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  logic taken;
  logic exec_done;
  logic resume;

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = flags_q[FLAG_Z];
      OP_JC:   taken = flags_q[FLAG_C];
      OP_JN:   taken = flags_q[FLAG_N];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    exec_done = 1'b1;
    if (op == OP_IN)       exec_done = in_valid;
    else if (op == OP_OUT) exec_done = out_ready;
  end

  // HALT keeps its own address so re-running re-executes it.
  assign pc_d   = (op == OP_HALT) ? pc_q : (taken ? imm : pc_q + ADDR_W'(1));
  // Continue only when free-running; a stepped instruction or falling run parks in HALT.
  assign resume = run && !step_q && (op != OP_HALT);

  assign in_ready  = (state_q == S_EXEC) && (op == OP_IN) && in_valid;
  assign out_valid = (state_q == S_EXEC) && (op == OP_OUT);
  assign out_data  = out_valid ? rd_val : '0;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_data  = regs_q[dbg_sel];

  // Memory is not reset; the external load port only works while halted.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [IW-1:0]     mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    if (state_q == S_HALT && prog_we) begin
      mem_we = 1'b1;
    end else if (state_q == S_MEM && op == OP_ST) begin
      mem_we    = 1'b1;
      mem_waddr = mem_addr;
      mem_wdata = IW'(rd_val);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HALT;
      pc_q    <= '0;
      instr_q <= '0;
      flags_q <= '0;
      step_q  <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_HALT: begin
          if (run || step) begin
            state_q <= S_FETCH;
            step_q  <= !run;
          end
        end
        S_FETCH: begin
          instr_q <= mem_q[pc_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (op == OP_LD || op == OP_ST) begin
            state_q <= S_MEM;
          end else if (exec_done) begin
            if (is_alu_op(op)) begin
              flags_q <= alu_flags;
              if (op != OP_CMP) regs_q[rd] <= alu_res;
            end
            if (op == OP_IN) regs_q[rd] <= in_data;
            pc_q    <= pc_d;
            state_q <= resume ? S_FETCH : S_HALT;
          end
        end
        S_MEM: begin
          if (op == OP_LD) regs_q[rd] <= DATA_W'(mem_q[mem_addr]);
          pc_q    <= pc_d;
          state_q <= resume ? S_FETCH : S_HALT;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: directed programs plus random programs against an ISA-level model.
// Latency: n/a.
// Backpressure: I/O ports driven manually or randomly by a single I/O process.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  pc;
  logic [11:0] instr;
  logic        halted;
  logic [1:0]  dbg_sel = '0;
  logic [7:0]  dbg_data;

  cpu_multicycle dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .instr(instr), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // I/O control: manual values or random when auto_io is set.
  bit         auto_io = 1'b0;
  logic       man_iv = 1'b0;
  logic [7:0] man_id = '0;
  logic       man_or = 1'b0;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];

  // ISA-level reference state.
  logic [11:0] m_mem [16];
  logic [7:0]  m_reg [4];
  logic [3:0]  m_pc;
  bit          m_z, m_c, m_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [3:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Inputs change at negedge+1, handshakes sampled at negedge+2, main thread works at negedge+3.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (auto_io) begin
        in_valid  = ($urandom_range(0, 2) == 0);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(0, 2) == 0);
      end else begin
        in_valid  = man_iv;
        in_data   = man_id;
        out_ready = man_or;
      end
      #1;
      if (in_valid && in_ready)   in_q.push_back(in_data);
      if (out_valid && out_ready) out_q.push_back(out_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic rd_reg(input int i, output logic [7:0] v);
    dbg_sel = 2'(i);
    #1;
    v = dbg_data;
  endtask

  task automatic load(input logic [3:0] a, input logic [11:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_pc = '0; m_z = 0; m_c = 0; m_n = 0;
  endtask

  // Pulse step and wait for HALT; cyc = cycles spent in FETCH..completion.
  task automatic step_one(output int cyc);
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 0;
    while (!halted && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!halted) check("step_timeout", 32'(halted), 32'd1);
  endtask

  // One instruction of the reference ISA; returns expected latency (0 = not checked).
  task automatic m_exec(input logic [11:0] ins, output int lat);
    int op, rd, rs, imm, a, b, r;
    logic [3:0] nxt;
    op = 32'(ins[11:8]); rd = 32'(ins[7:6]); rs = 32'(ins[5:4]); imm = 32'(ins[3:0]);
    a = 32'(m_reg[rd]); b = 32'(m_reg[rs]);
    nxt = m_pc + 4'd1;
    lat = 2;
    case (op)
      1, 2, 3, 4, 5, 14: begin
        case (op)
          1:       r = a + b;
          5:       r = a + imm;
          2, 14:   r = a - b;
          3:       r = a & b;
          default: r = a | b;
        endcase
        m_c = (op == 1 || op == 5) ? (r > 255) : ((op == 2 || op == 14) ? (a < b) : 1'b0);
        r = r & 255;
        m_z = (r == 0);
        m_n = (r >= 128);
        if (op != 14) m_reg[rd] = 8'(r);
      end
      6:  begin m_reg[rd] = m_mem[b % 16][7:0]; lat = 3; end
      7:  begin m_mem[b % 16] = {4'h0, m_reg[rd]}; lat = 3; end
      8:  nxt = 4'(imm);
      9:  if (m_z) nxt = 4'(imm);
      10: if (m_c) nxt = 4'(imm);
      11: if (m_n) nxt = 4'(imm);
      12: begin
        lat = 0;
        check("in_hs_count", 32'(in_q.size()), 32'd1);
        if (in_q.size() > 0) m_reg[rd] = in_q.pop_front();
      end
      13: begin
        lat = 0;
        check("out_hs_count", 32'(out_q.size()), 32'd1);
        if (out_q.size() > 0) check("out_value", 32'(out_q.pop_front()), 32'(m_reg[rd]));
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  initial begin
    int cyc, k, rdy, vcnt, lat;
    logic [7:0] v;
    logic [11:0] ins;

    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    tick();
    reset = 1'b0;
    do_reset();

    // Reset state.
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      check($sformatf("rst_r%0d", i), 32'(v), 32'd0);
    end

    // Small program under run: 5+3 emitted, then HALT.
    load(4'd0, enc(4'h5, 2'd0, 2'd0, 4'd5));
    load(4'd1, enc(4'h5, 2'd1, 2'd0, 4'd3));
    load(4'd2, enc(4'h1, 2'd0, 2'd1, 4'd0));
    load(4'd3, enc(4'hD, 2'd0, 2'd0, 4'd0));
    load(4'd4, enc(4'hF, 2'd0, 2'd0, 4'd0));
    out_q.delete();
    man_or = 1'b1;
    run = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!halted && cyc < 300);
    run = 1'b0;
    check("prog_cycles", 32'(cyc), 32'd11);
    tick();
    man_or = 1'b0;
    check("prog_halted", 32'(halted), 32'd1);
    check("prog_halt_pc", 32'(pc), 32'd4);
    check("prog_out_count", 32'(out_q.size()), 32'd1);
    if (out_q.size() > 0) check("prog_out_data", 32'(out_q[0]), 32'd8);

    // SUB borrow and flag-driven jumps.
    do_reset();
    load(4'd0, enc(4'h5, 2'd0, 2'd0, 4'd2));
    load(4'd1, enc(4'h5, 2'd1, 2'd0, 4'd3));
    load(4'd2, enc(4'h2, 2'd0, 2'd1, 4'd0));
    load(4'd3, enc(4'hA, 2'd0, 2'd0, 4'd6));
    load(4'd6, enc(4'hB, 2'd0, 2'd0, 4'd9));
    load(4'd9, enc(4'h9, 2'd0, 2'd0, 4'd0));
    step_one(cyc);
    step_one(cyc);
    step_one(cyc);
    check("sub_lat", 32'(cyc), 32'd2);
    rd_reg(0, v);
    check("sub_r0", 32'(v), 32'hFF);
    step_one(cyc);
    check("jc_pc", 32'(pc), 32'd6);
    step_one(cyc);
    check("jn_pc", 32'(pc), 32'd9);
    step_one(cyc);
    check("jz_not_taken_pc", 32'(pc), 32'd10);

    // IN with delayed valid, then flags still from the earlier SUB.
    do_reset();
    load(4'd0, enc(4'h2, 2'd0, 2'd0, 4'd0));
    load(4'd1, enc(4'hC, 2'd2, 2'd0, 4'd0));
    load(4'd2, enc(4'h9, 2'd0, 2'd0, 4'd5));
    load(4'd5, enc(4'hD, 2'd2, 2'd0, 4'd0));
    step_one(cyc);
    step = 1'b1;
    tick();
    step = 1'b0;
    k = 0; rdy = 0;
    while (!halted && k < 300) begin
      if (k == 4) begin man_iv = 1'b1; man_id = 8'h2A; end
      tick();
      k++;
      if (in_ready) rdy++;
    end
    man_iv = 1'b0;
    check("in_ready_cycles", 32'(rdy), 32'd1);
    check("in_total_cycles", 32'(k), 32'd6);
    rd_reg(2, v);
    check("in_r2", 32'(v), 32'h2A);
    step_one(cyc);
    check("in_flags_kept_pc", 32'(pc), 32'd5);

    // OUT held for three cycles of backpressure.
    step = 1'b1;
    tick();
    step = 1'b0;
    k = 0; vcnt = 0;
    while (!halted && k < 300) begin
      tick();
      k++;
      if (out_valid) begin
        vcnt++;
        check("out_stable_data", 32'(out_data), 32'h2A);
        check("out_stall_pc", 32'(pc), 32'd5);
        if (vcnt == 3) man_or = 1'b1;
      end
    end
    man_or = 1'b0;
    check("out_valid_cycles", 32'(vcnt), 32'd4);
    check("out_pc_after", 32'(pc), 32'd6);

    // Stepped ST at the top address wraps pc; store read back by LD.
    do_reset();
    load(4'd0, enc(4'h5, 2'd0, 2'd0, 4'd7));
    load(4'd1, enc(4'h5, 2'd1, 2'd0, 4'd15));
    load(4'd2, enc(4'h8, 2'd0, 2'd0, 4'd15));
    load(4'd15, enc(4'h7, 2'd0, 2'd1, 4'd0));
    step_one(cyc);
    step_one(cyc);
    step_one(cyc);
    check("jmp15_pc", 32'(pc), 32'd15);
    tick();
    check("step_stays_halted", 32'(halted), 32'd1);
    load(4'd0, enc(4'h8, 2'd0, 2'd0, 4'd0));
    step_one(cyc);
    check("st_lat", 32'(cyc), 32'd3);
    check("st_pc_wrap", 32'(pc), 32'd0);
    step_one(cyc);
    check("jmp0_pc", 32'(pc), 32'd0);
    load(4'd0, enc(4'h6, 2'd2, 2'd1, 4'd0));
    step_one(cyc);
    check("ld_lat", 32'(cyc), 32'd3);
    rd_reg(2, v);
    check("ld_r2_from_store", 32'(v), 32'd7);
    check("ld_pc", 32'(pc), 32'd1);

    // Reset during an IN stall; program writes while running are ignored.
    do_reset();
    load(4'd0, enc(4'h5, 2'd3, 2'd0, 4'd9));
    load(4'd1, enc(4'hC, 2'd1, 2'd0, 4'd0));
    run = 1'b1;
    repeat (6) tick();
    check("stall_pc", 32'(pc), 32'd1);
    check("stall_halted", 32'(halted), 32'd0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = enc(4'hF, 2'd0, 2'd0, 4'd0);
    tick();
    prog_we = 1'b0;
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    check("rst2_halted", 32'(halted), 32'd1);
    check("rst2_pc", 32'(pc), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      check($sformatf("rst2_r%0d", i), 32'(v), 32'd0);
    end
    step_one(cyc);
    check("mem_kept_instr", 32'(instr), 32'(enc(4'h5, 2'd3, 2'd0, 4'd9)));
    rd_reg(3, v);
    check("mem_kept_r3", 32'(v), 32'd9);

    // Random programs, stepped one instruction at a time against the model.
    for (int p = 0; p < 3; p++) begin
      do_reset();
      for (int a = 0; a < 16; a++) begin
        ins = {4'($urandom_range(0, 14)), 8'($urandom)};
        load(4'(a), ins);
      end
      in_q.delete();
      out_q.delete();
      auto_io = 1'b1;
      for (int s = 0; s < 60; s++) begin
        ins = m_mem[m_pc];
        step_one(cyc);
        m_exec(ins, lat);
        if (lat != 0) check("rnd_lat", 32'(cyc), 32'(lat));
        check("rnd_instr", 32'(instr), 32'(ins));
        check("rnd_pc", 32'(pc), 32'(m_pc));
        for (int i = 0; i < 4; i++) begin
          rd_reg(i, v);
          check($sformatf("rnd_r%0d", i), 32'(v), 32'(m_reg[i]));
        end
      end
      auto_io = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
